// File: rtl/ucode_pkg.sv
// ucode_pkg: shared definitions for the microcode sequencer slice.
//   uc_state_e  - sequencer state encoding (IDLE/RUN/DONE)
//   UC_AW       - microcode ROM address width
//   UC_RST_ADDR - ROM address held outside of a routine
//   SEL_*       - {bit1,bit0} branch-select codes from branch_bit
package ucode_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } uc_state_e;

  localparam int unsigned UC_AW       = 9;
  localparam logic [8:0]  UC_RST_ADDR = 9'h000;

  localparam logic [1:0] SEL_NEXT0 = 2'b00;
  localparam logic [1:0] SEL_NEXT1 = 2'b01;
  localparam logic [1:0] SEL_JUMP  = 2'b10;
  localparam logic [1:0] SEL_INC   = 2'b11;

endpackage

// File: rtl/mx3_9.sv
// mx3_9: three-input 9-bit mux used as the next-address selector.
//   a   in  9  sequential-next address (sel 00/01)
//   b   in  9  branch target           (sel 10)
//   c   in  9  incremented address     (sel 11)
//   sel in  2  {bit1,bit0}
//   y   out 9  selected address
module mx3_9
  import ucode_pkg::*;
(
  input  logic [8:0] a,
  input  logic [8:0] b,
  input  logic [8:0] c,
  input  logic [1:0] sel,
  output logic [8:0] y
);

  always_comb begin
    y = a;
    unique case (sel)
      SEL_NEXT0, SEL_NEXT1: y = a;
      SEL_JUMP:             y = b;
      SEL_INC:              y = c;
      default:              y = a;
    endcase
  end

endmodule

// File: rtl/ucode_seq.sv
// ucode_seq: microcode sequencer. Holds the ROM address, steps it per the
// branch select from branch_bit, and reports routine completion to the IU.
//   clk          in  1   core clock
//   reset_l      in  1   asynchronous active-low reset
//   ucode_start  in  1   enter routine at entry_addr (pulse)
//   entry_addr   in  AW  routine entry address
//   u_next_addr  in  AW  ROM field: sequential next
//   u_jump_addr  in  AW  ROM field: branch target
//   u_end        in  1   ROM field: last uinstr of routine
//   bit1, bit0   in  1   branch select
//   hold         in  1   pipeline stall
//   rom_addr     out AW  registered ROM address
//   ucode_busy   out 1   routine in progress
//   ucode_done   out 1   routine finished normally (pulse)
//   ucode_err    out 1   watchdog abort (pulse)
module ucode_seq
  import ucode_pkg::*;
#(
  parameter int unsigned AW      = UC_AW,
  parameter int unsigned MAX_CYC = 255
) (
  input  logic          clk,
  input  logic          reset_l,
  input  logic          ucode_start,
  input  logic [AW-1:0] entry_addr,
  input  logic [AW-1:0] u_next_addr,
  input  logic [AW-1:0] u_jump_addr,
  input  logic          u_end,
  input  logic          bit1,
  input  logic          bit0,
  input  logic          hold,
  output logic [AW-1:0] rom_addr,
  output logic          ucode_busy,
  output logic          ucode_done,
  output logic          ucode_err
);

  localparam logic [7:0] CNT_LAST = 8'(MAX_CYC - 1);

  uc_state_e     state_q;
  logic [AW-1:0] rom_addr_q;
  logic [AW-1:0] inc_d;
  logic [AW-1:0] mux_d;
  logic [7:0]    cnt_q;
  logic          err_q;

  // Incrementer wraps naturally at 2^AW.
  assign inc_d = rom_addr_q + 1'b1;

  mx3_9 u_mux (
    .a   (u_next_addr),
    .b   (u_jump_addr),
    .c   (inc_d),
    .sel ({bit1, bit0}),
    .y   (mux_d)
  );

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q    <= ST_IDLE;
      rom_addr_q <= UC_RST_ADDR;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        // DONE accepts a start exactly like IDLE for back-to-back routines.
        ST_IDLE, ST_DONE: begin
          if (ucode_start) begin
            rom_addr_q <= entry_addr;
            cnt_q      <= '0;
            state_q    <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // hold outranks both end-of-routine and the watchdog.
          if (!hold) begin
            if (u_end) begin
              rom_addr_q <= UC_RST_ADDR;
              state_q    <= ST_DONE;
            end else if (cnt_q == CNT_LAST) begin
              rom_addr_q <= UC_RST_ADDR;
              err_q      <= 1'b1;
              state_q    <= ST_IDLE;
            end else begin
              cnt_q      <= cnt_q + 8'd1;
              rom_addr_q <= mux_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rom_addr   = rom_addr_q;
  assign ucode_busy = (state_q == ST_RUN);
  assign ucode_done = (state_q == ST_DONE);
  assign ucode_err  = err_q;

endmodule
